// File: rtl/dcache_mem_responder_if.sv
// dcache command/response bus between the core (master) and a memory-side
// responder (slave).
//   dcache_cmd_valid          master->slave  command present
//   dcache_cmd_ready          slave->master  responder can accept a command
//   dcache_cmd_payload_addr   master->slave  byte address
//   dcache_cmd_payload_wen    master->slave  1 = write, 0 = read
//   dcache_cmd_payload_wdata  master->slave  lane-aligned write data
//   dcache_cmd_payload_wstrb  master->slave  byte enables
//   dcache_cmd_payload_size   master->slave  access size (informational)
//   dcache_rsp_valid          slave->master  one-cycle response pulse
//   dcache_rsp_payload_data   slave->master  aligned doubleword
interface dcache_mem_responder_if;
  logic        dcache_cmd_valid;
  logic        dcache_cmd_ready;
  logic [63:0] dcache_cmd_payload_addr;
  logic        dcache_cmd_payload_wen;
  logic [63:0] dcache_cmd_payload_wdata;
  logic [7:0]  dcache_cmd_payload_wstrb;
  logic [2:0]  dcache_cmd_payload_size;
  logic        dcache_rsp_valid;
  logic [63:0] dcache_rsp_payload_data;

  modport master (
    output dcache_cmd_valid, dcache_cmd_payload_addr, dcache_cmd_payload_wen,
           dcache_cmd_payload_wdata, dcache_cmd_payload_wstrb, dcache_cmd_payload_size,
    input  dcache_cmd_ready, dcache_rsp_valid, dcache_rsp_payload_data
  );

  modport slave (
    input  dcache_cmd_valid, dcache_cmd_payload_addr, dcache_cmd_payload_wen,
           dcache_cmd_payload_wdata, dcache_cmd_payload_wstrb, dcache_cmd_payload_size,
    output dcache_cmd_ready, dcache_rsp_valid, dcache_rsp_payload_data
  );
endinterface

// File: rtl/dcache_mem_responder.sv
// Memory-side responder for the dcache command/response bus. Accepts one
// command at a time, performs byte-masked writes / doubleword reads on an
// internal RAM of 2^AW doublewords mapped at BASE_ADDR, and returns read data
// LATENCY cycles (1..15) after acceptance.
// Ports:
//   clk    clock
//   reset  asynchronous active-high reset (RAM contents are not reset)
//   bus    dcache_mem_responder_if.slave command/response bus
//   err_o  sticky out-of-range access flag, cleared only by reset
// Optional feature macro: DCACHE_RSP_WRITE_ACK_EN -- when defined, writes also
// produce a response pulse (data 0) LATENCY cycles after acceptance.
module dcache_mem_responder #(
  parameter logic [63:0] BASE_ADDR = 64'h8000_0000,
  parameter int unsigned AW        = 16,
  parameter int unsigned LATENCY   = 2
) (
  input  logic                          clk,
  input  logic                          reset,
  dcache_mem_responder_if.slave         bus,
  output logic                          err_o
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RSP  = 2'd2;

  logic [63:0] mem [0:(2**AW)-1];

  logic [1:0]    state;
  logic [3:0]    cnt;
  logic [63:0]   rdata;
  logic          err;
  logic [63:0]   off;
  logic          in_range;
  logic [AW-1:0] idx;
  logic          wen;
  logic          accept;
  logic          rsp_cmd;
  logic          unused;

  assign off      = bus.dcache_cmd_payload_addr - BASE_ADDR;
  assign in_range = (off[63:AW+3] == '0);
  assign idx      = off[AW+2:3];
  assign wen      = bus.dcache_cmd_payload_wen;
  assign accept   = bus.dcache_cmd_valid && (state != S_WAIT);
  assign unused   = ^{off[2:0], bus.dcache_cmd_payload_size};

  // rsp_cmd: the accepted command travels the WAIT/RSP path
`ifdef DCACHE_RSP_WRITE_ACK_EN
  assign rsp_cmd = 1'b1;
`else
  assign rsp_cmd = ~wen;
`endif

  assign bus.dcache_cmd_ready        = (state != S_WAIT);
  assign bus.dcache_rsp_valid        = (state == S_RSP);
  assign bus.dcache_rsp_payload_data = rdata;
  assign err_o                       = err;

  // RAM: no reset; writes are suppressed while reset is held so that an
  // accept cannot occur during reset.
  always_ff @(posedge clk) begin
    if (!reset && accept && wen && in_range) begin
      for (int unsigned i = 0; i < 8; i++) begin
        if (bus.dcache_cmd_payload_wstrb[i])
          mem[idx][8*i +: 8] <= bus.dcache_cmd_payload_wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
      cnt   <= '0;
      rdata <= '0;
      err   <= 1'b0;
    end else if (accept) begin
      if (!in_range) err <= 1'b1;
      if (rsp_cmd) begin
        // write acks and out-of-range reads both return zero
        rdata <= (wen || !in_range) ? '0 : mem[idx];
        if (LATENCY == 1) begin
          state <= S_RSP;
        end else begin
          state <= S_WAIT;
          cnt   <= 4'(LATENCY - 2);
        end
      end else begin
        state <= S_IDLE;
      end
    end else begin
      case (state)
        S_WAIT: begin
          if (cnt == '0) state <= S_RSP;
          else           cnt   <= cnt - 4'd1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dcache_mem_responder.sv
module tb_dcache_mem_responder;
  localparam logic [63:0] BASE = 64'h8000_0000;
  localparam int AW = 16;
  localparam logic [63:0] SPAN = 64'd1 << (AW + 3);
`ifdef DCACHE_RSP_WRITE_ACK_EN
  localparam bit WACK = 1'b1;
`else
  localparam bit WACK = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  dcache_mem_responder_if bus2 ();
  dcache_mem_responder_if bus1 ();
  dcache_mem_responder_if bus4 ();
  logic err2, err1, err4;

  dcache_mem_responder #(.BASE_ADDR(BASE), .AW(AW), .LATENCY(2)) u_dut (
    .clk(clk), .reset(reset), .bus(bus2), .err_o(err2));
  dcache_mem_responder #(.BASE_ADDR(BASE), .AW(AW), .LATENCY(1)) u_dut1 (
    .clk(clk), .reset(reset), .bus(bus1), .err_o(err1));
  dcache_mem_responder #(.BASE_ADDR(BASE), .AW(AW), .LATENCY(4)) u_dut4 (
    .clk(clk), .reset(reset), .bus(bus4), .err_o(err4));

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // bus index: 0 -> LATENCY 2, 1 -> LATENCY 1, 2 -> LATENCY 4
  function automatic int lat_of(input int b);
    case (b)
      0:       return 2;
      1:       return 1;
      default: return 4;
    endcase
  endfunction

  function automatic logic get_ready(input int b);
    case (b)
      0:       return bus2.dcache_cmd_ready;
      1:       return bus1.dcache_cmd_ready;
      default: return bus4.dcache_cmd_ready;
    endcase
  endfunction

  function automatic logic get_rv(input int b);
    case (b)
      0:       return bus2.dcache_rsp_valid;
      1:       return bus1.dcache_rsp_valid;
      default: return bus4.dcache_rsp_valid;
    endcase
  endfunction

  function automatic logic [63:0] get_data(input int b);
    case (b)
      0:       return bus2.dcache_rsp_payload_data;
      1:       return bus1.dcache_rsp_payload_data;
      default: return bus4.dcache_rsp_payload_data;
    endcase
  endfunction

  function automatic logic get_err(input int b);
    case (b)
      0:       return err2;
      1:       return err1;
      default: return err4;
    endcase
  endfunction

  task automatic set_cmd(input int b, input logic v, input logic w, input logic [63:0] a,
                         input logic [63:0] wd, input logic [7:0] ws);
    case (b)
      0: begin
        bus2.dcache_cmd_valid = v; bus2.dcache_cmd_payload_wen = w; bus2.dcache_cmd_payload_addr = a;
        bus2.dcache_cmd_payload_wdata = wd; bus2.dcache_cmd_payload_wstrb = ws; bus2.dcache_cmd_payload_size = 3'd3;
      end
      1: begin
        bus1.dcache_cmd_valid = v; bus1.dcache_cmd_payload_wen = w; bus1.dcache_cmd_payload_addr = a;
        bus1.dcache_cmd_payload_wdata = wd; bus1.dcache_cmd_payload_wstrb = ws; bus1.dcache_cmd_payload_size = 3'd3;
      end
      default: begin
        bus4.dcache_cmd_valid = v; bus4.dcache_cmd_payload_wen = w; bus4.dcache_cmd_payload_addr = a;
        bus4.dcache_cmd_payload_wdata = wd; bus4.dcache_cmd_payload_wstrb = ws; bus4.dcache_cmd_payload_size = 3'd3;
      end
    endcase
  endtask

  // One command, called and returning at a negedge. Checks latency, ready-low
  // duration, data and single-cycle pulse for responses; no pulse otherwise.
  task automatic cmd(input int b, input logic w, input logic [63:0] a, input logic [63:0] wd,
                     input logic [7:0] ws, input logic [63:0] exp_data, input string name);
    int k;
    int rlow;
    bit seen;
    k = 0;
    while (!get_ready(b) && k < 20) begin @(negedge clk); k++; end
    check({name, "_ready"}, get_ready(b), 1);
    set_cmd(b, 1'b1, w, a, wd, ws);
    @(negedge clk);
    set_cmd(b, 1'b0, 1'b0, '0, '0, '0);
    if (!w || WACK) begin
      seen = 0; k = 0; rlow = 0;
      while (!seen && k < 20) begin
        if (get_rv(b)) seen = 1;
        else begin
          if (!get_ready(b)) rlow++;
          @(negedge clk);
          k++;
        end
      end
      check({name, "_lat"}, k + 1, lat_of(b));
      check({name, "_rdylow"}, rlow, lat_of(b) - 1);
      check({name, "_data"}, get_data(b), w ? 64'h0 : exp_data);
      @(negedge clk);
      check({name, "_pulse_end"}, get_rv(b), 0);
    end else begin
      check({name, "_norsp"}, get_rv(b), 0);
      check({name, "_wr_ready"}, get_ready(b), 1);
    end
  endtask

  typedef struct {
    logic        wen;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [7:0]  wstrb;
    logic [63:0] exp_data;
    logic        exp_err;
  } vec_t;

  vec_t tv [12];

  // reference model state for the randomized phase
  logic [63:0] mdl [3][16];
  int          acc [3];
  int          rsp [3];
  logic [63:0] edat [3];
  bit          merr [3];
  int          nwr [3];

  initial begin
    #1000000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] a, wd;
    logic [7:0]  ws;
    logic        w;
    bit          inr, exp_rdy, exp_rv;
    int          ix, e, cyc;

    tv[0]  = '{1'b1, BASE + 64'h10,     64'h1122334455667788, 8'hFF, 64'h0, 1'b0};
    tv[1]  = '{1'b0, BASE + 64'h14,     64'h0, 8'h00, 64'h1122334455667788, 1'b0};
    tv[2]  = '{1'b1, BASE + 64'h10,     64'hAAAAAAAAAAAAAAAA, 8'h0F, 64'h0, 1'b0};
    tv[3]  = '{1'b0, BASE + 64'h10,     64'h0, 8'h00, 64'h11223344AAAAAAAA, 1'b0};
    tv[4]  = '{1'b1, BASE + 64'h10,     64'hFFFFFFFFFFFFFFFF, 8'h00, 64'h0, 1'b0};
    tv[5]  = '{1'b0, BASE + 64'h17,     64'h0, 8'h00, 64'h11223344AAAAAAAA, 1'b0};
    tv[6]  = '{1'b1, BASE,              64'hDEADBEEFCAFEF00D, 8'hFF, 64'h0, 1'b0};
    tv[7]  = '{1'b0, 64'h7FFF_FFF8,     64'h0, 8'h00, 64'h0, 1'b1};
    tv[8]  = '{1'b1, BASE + SPAN,       64'h0123456789ABCDEF, 8'hFF, 64'h0, 1'b1};
    tv[9]  = '{1'b0, BASE,              64'h0, 8'h00, 64'hDEADBEEFCAFEF00D, 1'b1};
    tv[10] = '{1'b1, BASE + SPAN - 8,   64'h5A5A5A5A5A5A5A5A, 8'hFF, 64'h0, 1'b1};
    tv[11] = '{1'b0, BASE + SPAN - 3,   64'h0, 8'h00, 64'h5A5A5A5A5A5A5A5A, 1'b1};

    for (int b = 0; b < 3; b++) set_cmd(b, 1'b0, 1'b0, '0, '0, '0);

    // reset and idle
    #1 reset = 1'b1;
    #1;
    for (int b = 0; b < 3; b++) begin
      check($sformatf("rst_ready%0d", b), get_ready(b), 1);
      check($sformatf("rst_rv%0d", b), get_rv(b), 0);
      check($sformatf("rst_data%0d", b), get_data(b), 0);
      check($sformatf("rst_err%0d", b), get_err(b), 0);
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("idle_ready", get_ready(0), 1);
      check("idle_rv", get_rv(0), 0);
      check("idle_err", get_err(0), 0);
    end

    // table-driven vectors on the LATENCY=2 instance
    for (int i = 0; i < 12; i++) begin
      cmd(0, tv[i].wen, tv[i].addr, tv[i].wdata, tv[i].wstrb, tv[i].exp_data, $sformatf("vec%0d", i));
      check($sformatf("vec%0d_err", i), get_err(0), tv[i].exp_err);
    end

    // back-to-back reads at LATENCY=1
    for (int i = 0; i < 4; i++)
      cmd(1, 1'b1, BASE + 64'(8 * i), 64'hA5A5_0000_0000_0000 | 64'(i * 257), 8'hFF, 64'h0, "b2b_wr");
    for (int i = 0; i < 4; i++) begin
      set_cmd(1, 1'b1, 1'b0, BASE + 64'(8 * i), '0, '0);
      @(negedge clk);
      check("b2b_ready", get_ready(1), 1);
      check("b2b_rv", get_rv(1), 1);
      check("b2b_data", get_data(1), 64'hA5A5_0000_0000_0000 | 64'(i * 257));
    end
    set_cmd(1, 1'b0, 1'b0, '0, '0, '0);
    @(negedge clk);
    check("b2b_end", get_rv(1), 0);

    // reset two cycles into a LATENCY=4 read
    cmd(2, 1'b1, BASE + 64'h28, 64'h0F0E0D0C0B0A0908, 8'hFF, 64'h0, "mid_wr");
    set_cmd(2, 1'b1, 1'b0, BASE + 64'h28, '0, '0);
    @(negedge clk);
    set_cmd(2, 1'b0, 1'b0, '0, '0, '0);
    check("mid_wait", get_ready(2), 0);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("mid_async_ready", get_ready(2), 1);
    check("mid_async_rv", get_rv(2), 0);
    check("mid_async_data", get_data(2), 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("mid_no_pulse", get_rv(2), 0);
      check("mid_ready", get_ready(2), 1);
    end
    cmd(2, 1'b0, BASE + 64'h28, '0, '0, 64'h0F0E0D0C0B0A0908, "mid_readback");

    // randomized traffic on all three instances against the reference model
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    for (int b = 0; b < 3; b++) begin
      acc[b] = -1; rsp[b] = -1; edat[b] = '0; merr[b] = 0; nwr[b] = 0;
    end
    cyc = 0;
    for (int c = 0; c < 500; c++) begin
      for (int b = 0; b < 3; b++) begin
        exp_rdy = !(cyc >= acc[b] && cyc < rsp[b]);
        exp_rv  = (cyc == rsp[b]);
        check($sformatf("rnd_ready%0d", b), get_ready(b), exp_rdy);
        check($sformatf("rnd_rv%0d", b), get_rv(b), exp_rv);
        check($sformatf("rnd_err%0d", b), get_err(b), merr[b]);
        if (exp_rv) check($sformatf("rnd_data%0d", b), get_data(b), edat[b]);

        if (nwr[b] < 16) begin
          w = 1'b1; a = BASE + 64'(8 * nwr[b]); ws = 8'hFF;
        end else begin
          w  = 1'($urandom_range(1));
          ws = 8'($urandom);
          if ($urandom_range(15) == 0) begin
            if ($urandom_range(1) == 1) a = BASE - 64'(8 * $urandom_range(1, 100));
            else                        a = BASE + SPAN + 64'(8 * $urandom_range(0, 100));
          end else begin
            a = BASE + 64'(8 * $urandom_range(15)) + 64'($urandom_range(7));
          end
        end
        wd = {$urandom, $urandom};

        if (exp_rdy && $urandom_range(9) < 7) begin
          e   = cyc + 1;
          inr = (a >= BASE) && (a - BASE < SPAN);
          ix  = inr ? int'((a - BASE) / 8) : 0;
          if (!inr) merr[b] = 1;
          if (w) begin
            if (inr)
              for (int j = 0; j < 8; j++)
                if (ws[j]) mdl[b][ix][8*j +: 8] = wd[8*j +: 8];
            if (WACK) begin acc[b] = e; rsp[b] = e + lat_of(b) - 1; edat[b] = '0; end
            if (nwr[b] < 16) nwr[b]++;
          end else begin
            edat[b] = inr ? mdl[b][ix] : 64'h0;
            acc[b]  = e;
            rsp[b]  = e + lat_of(b) - 1;
          end
          set_cmd(b, 1'b1, w, a, wd, ws);
        end else if (!exp_rdy && $urandom_range(1) == 1) begin
          // presented while busy: must be ignored
          set_cmd(b, 1'b1, w, a, wd, ws);
        end else begin
          set_cmd(b, 1'b0, 1'b0, '0, '0, '0);
        end
      end
      @(negedge clk);
      cyc++;
    end
    for (int b = 0; b < 3; b++) set_cmd(b, 1'b0, 1'b0, '0, '0, '0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
